// File: rtl/hazard_pc_ctrl_pkg.sv
// Shared types and constants for the PC-select / pipeline hazard controller.
package hazard_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int   REG_ADDR_W = 5;
  localparam logic PCSEL_SEQ  = 1'b0;
  localparam logic PCSEL_BR   = 1'b1;

endpackage

// File: rtl/hazard_pc_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_pc_ctrl.sv
// Resolves memory freezes, load-use bubbles and ID-stage taken branches into PC-mux and
// pipeline-register controls, and counts redirects and stall cycles.
module hazard_pc_ctrl
  import hazard_pc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_branch_i,
  input  logic                  id_rs_equal_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  mem_stall_i,
  output logic                  pc_select_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  pipe_freeze_o,
  output logic [CNT_W-1:0]      redirect_cnt_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output hz_state_e             state_o
);

  hz_state_e  state_q, state_d;
  logic       lu_pend_q, lu_pend_d;
  logic       lu, lu_live, take_br;
  logic [CNT_W-1:0] redirect_q, stall_q;

  // Handshake-free block: every output is a per-cycle level, valid whenever rst_i is low.
  assign lu      = ex_memread_i && (ex_rd_addr_i != '0) &&
                   ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));
  // In LU_STALL the EX stage holds the bubble, so a matching load there is stale.
  assign lu_live = lu && (state_q != LU_STALL);
  assign take_br = id_branch_i && id_rs_equal_i;

  always_comb begin
    pc_select_o   = PCSEL_SEQ;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    state_d       = RUN;
    lu_pend_d     = lu_pend_q;
    if (rst_i) begin
      lu_pend_d = 1'b0;
    end else if (mem_stall_i) begin
      pipe_freeze_o = 1'b1;
      state_d       = MEM_WAIT;
      lu_pend_d     = lu_live || lu_pend_q;
    end else if (lu_live || lu_pend_q) begin
      idex_bubble_o = 1'b1;
      state_d       = LU_STALL;
      lu_pend_d     = 1'b0;
    end else begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      if (take_br) begin
        pc_select_o  = PCSEL_BR;
        ifid_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      lu_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lu_pend_q <= lu_pend_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (pc_select_o),
    .count (redirect_q)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clr   (rst_i),
    .inc   (pipe_freeze_o || idex_bubble_o),
    .count (stall_q)
  );

  assign redirect_cnt_o = rst_i ? '0 : redirect_q;
  assign stall_cnt_o    = rst_i ? '0 : stall_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_hazard_pc_ctrl.sv
// Directed bench for hazard_pc_ctrl: a rule-level model checked every cycle plus literal pins.
module tb_hazard_pc_ctrl;
  import hazard_pc_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             id_branch_i = 1'b0;
  logic             id_rs_equal_i = 1'b0;
  logic [4:0]       id_rs1_addr_i = '0;
  logic [4:0]       id_rs2_addr_i = '0;
  logic             ex_memread_i = 1'b0;
  logic [4:0]       ex_rd_addr_i = '0;
  logic             mem_stall_i = 1'b0;
  logic             pc_select_o, pc_write_o, ifid_write_o, ifid_flush_o;
  logic             idex_bubble_o, pipe_freeze_o;
  logic [CNT_W-1:0] redirect_cnt_o, stall_cnt_o;
  hz_state_e        state_o;

  int checks = 0;
  int failures = 0;

  hazard_pc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_branch_i    (id_branch_i),
    .id_rs_equal_i  (id_rs_equal_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rd_addr_i   (ex_rd_addr_i),
    .mem_stall_i    (mem_stall_i),
    .pc_select_o    (pc_select_o),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .redirect_cnt_o (redirect_cnt_o),
    .stall_cnt_o    (stall_cnt_o),
    .state_o        (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what happened last cycle (bubble, freeze), a pending bubble, and two integer counts.
  logic m_bubble_last = 1'b0;
  logic m_frozen_last = 1'b0;
  logic m_pend = 1'b0;
  int   m_redir = 0;
  int   m_stall = 0;

  logic      e_sel, e_pcw, e_ifw, e_fl, e_bub, e_frz, m_lu;
  int        e_rc, e_sc;
  hz_state_e e_state;

  // Compare process: runs every negedge, then advances the model to the next cycle.
  always @(negedge clk) begin
    {e_sel, e_pcw, e_ifw, e_fl, e_bub, e_frz} = '0;
    e_rc = 0;
    e_sc = 0;
    m_lu = ex_memread_i && (ex_rd_addr_i != 0) &&
           (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i) && !m_bubble_last;
    if (!rst_i) begin
      if (mem_stall_i) e_frz = 1'b1;
      else if (m_lu || m_pend) e_bub = 1'b1;
      else begin
        e_pcw = 1'b1;
        e_ifw = 1'b1;
        e_sel = id_branch_i && id_rs_equal_i;
        e_fl  = id_branch_i && id_rs_equal_i;
      end
      e_rc = m_redir;
      e_sc = m_stall;
    end
    e_state = m_bubble_last ? LU_STALL : (m_frozen_last ? MEM_WAIT : RUN);

    check("ctrl{sel,pcw,ifw,flush,bub,frz}",
          32'({pc_select_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o}),
          32'({e_sel, e_pcw, e_ifw, e_fl, e_bub, e_frz}));
    check("redirect_cnt", 32'(redirect_cnt_o), 32'(e_rc));
    check("stall_cnt", 32'(stall_cnt_o), 32'(e_sc));
    check("state", 32'(state_o), 32'(e_state));

    if (rst_i) begin
      m_bubble_last = 1'b0;
      m_frozen_last = 1'b0;
      m_pend        = 1'b0;
      m_redir       = 0;
      m_stall       = 0;
    end else begin
      m_pend        = mem_stall_i ? (m_pend || m_lu) : 1'b0;
      m_bubble_last = e_bub;
      m_frozen_last = e_frz;
      if (e_sel && m_redir < CMAX) m_redir++;
      if ((e_frz || e_bub) && m_stall < CMAX) m_stall++;
    end
  end

  // Driver tasks
  task automatic set_in(input logic br, input logic eq, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                        input logic st);
    id_branch_i   = br;
    id_rs_equal_i = eq;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    ex_memread_i  = mr;
    ex_rd_addr_i  = rd;
    mem_stall_i   = st;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a taken branch present: every control must stay low.
    set_in(1, 1, 5'd1, 5'd2, 1, 5'd1, 0);
    mid_cycle();
    check("rst pc_select", 32'(pc_select_o), 32'd0);
    check("rst pc_write", 32'(pc_write_o), 32'd0);
    check("rst redirect_cnt", 32'(redirect_cnt_o), 32'd0);
    next_cycle();
    next_cycle();
    rst_i = 1'b0;

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    set_in(0, 0, 5'd5, 5'd1, 1, 5'd5, 0);
    mid_cycle();
    check("lu pc_write", 32'(pc_write_o), 32'd0);
    check("lu bubble", 32'(idex_bubble_o), 32'd1);
    next_cycle();
    set_in(0, 0, 5'd5, 5'd1, 0, 5'd0, 0);
    mid_cycle();
    check("lu after pc_write", 32'(pc_write_o), 32'd1);
    check("lu stall_cnt", 32'(stall_cnt_o), 32'd1);
    next_cycle();

    // Taken branch, then not-taken.
    set_in(1, 1, 5'd3, 5'd4, 0, 5'd0, 0);
    mid_cycle();
    check("br pc_select", 32'(pc_select_o), 32'd1);
    check("br flush", 32'(ifid_flush_o), 32'd1);
    next_cycle();
    set_in(1, 0, 5'd3, 5'd4, 0, 5'd0, 0);
    mid_cycle();
    check("br redirect_cnt", 32'(redirect_cnt_o), 32'd1);
    check("br nt pc_select", 32'(pc_select_o), 32'd0);
    next_cycle();

    // Load-use with a taken branch: bubble first, redirect in the LU_STALL cycle.
    set_in(1, 1, 5'd2, 5'd3, 1, 5'd2, 0);
    mid_cycle();
    check("lubr bubble", 32'(idex_bubble_o), 32'd1);
    check("lubr sel first", 32'(pc_select_o), 32'd0);
    next_cycle();
    mid_cycle();
    check("lubr sel second", 32'(pc_select_o), 32'd1);
    check("lubr state", 32'(state_o), 32'(LU_STALL));
    next_cycle();

    // Freeze for 3 cycles over a load-use, then exactly one bubble.
    set_in(0, 0, 5'd5, 5'd1, 1, 5'd5, 1);
    for (int i = 0; i < 3; i++) begin
      mid_cycle();
      check("frz freeze", 32'(pipe_freeze_o), 32'd1);
      next_cycle();
    end
    set_in(0, 0, 5'd5, 5'd1, 1, 5'd5, 0);
    mid_cycle();
    check("frz bubble", 32'(idex_bubble_o), 32'd1);
    next_cycle();
    mid_cycle();
    check("frz no 2nd bubble", 32'(idex_bubble_o), 32'd0);
    check("frz stall_cnt", 32'(stall_cnt_o), 32'd6);
    next_cycle();

    // x0 destination never stalls.
    set_in(0, 0, 5'd0, 5'd0, 1, 5'd0, 0);
    mid_cycle();
    check("x0 pc_write", 32'(pc_write_o), 32'd1);
    next_cycle();

    // Freeze with a taken branch: redirect waits for release.
    set_in(1, 1, 5'd7, 5'd8, 0, 5'd0, 1);
    mid_cycle();
    check("frzbr sel held", 32'(pc_select_o), 32'd0);
    next_cycle();
    next_cycle();
    set_in(1, 1, 5'd7, 5'd8, 0, 5'd0, 0);
    mid_cycle();
    check("frzbr sel release", 32'(pc_select_o), 32'd1);
    next_cycle();

    // Saturation: 20 taken branches, then a long freeze.
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1, 5'(i), 5'(i + 1), 0, 5'd0, 0);
      next_cycle();
    end
    set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 1);
    mid_cycle();
    check("sat redirect_cnt", 32'(redirect_cnt_o), 32'd15);
    for (int i = 0; i < 10; i++) next_cycle();
    set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    mid_cycle();
    check("sat stall_cnt", 32'(stall_cnt_o), 32'd15);
    next_cycle();

    // Reset mid-MEM_WAIT with a pending bubble: no bubble after release.
    set_in(0, 0, 5'd9, 5'd1, 1, 5'd9, 1);
    next_cycle();
    next_cycle();
    set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 1);
    rst_i = 1'b1;
    mid_cycle();
    check("rstmw freeze low", 32'(pipe_freeze_o), 32'd0);
    next_cycle();
    rst_i = 1'b0;
    set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    mid_cycle();
    check("rstmw state", 32'(state_o), 32'(RUN));
    check("rstmw bubble", 32'(idex_bubble_o), 32'd0);
    check("rstmw stall_cnt", 32'(stall_cnt_o), 32'd0);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
